// File: rtl/reset_ce_pkg.sv
// Shared definitions for the reset / clock-enable generator.
// Holds the FSM state encoding and the default divisor constants so the
// top level and the bench agree on one set of rates.
package reset_ce_pkg;

  // Reset sequencer states: waiting for lock, timing the hold, released.
  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    COUNT = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int DEF_RST_CYCLES = 4096;
  localparam int DEF_PIX_DIV    = 4;
  localparam int DEF_CPU_NORMAL = 12;
  localparam int DEF_CPU_TURBO  = 8;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_ce_sync2.sv
// Two-flop synchronizer with asynchronous active-high clear.
// Ports:
//   clock  in  sampling clock
//   reset  in  async clear, output forced to 0
//   d_i    in  asynchronous level
//   q_o    out level synchronized to clock
module reset_ce_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // First flop may go metastable; the second gives it a full clock to settle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_ce.sv
// System reset and clock-enable generator fed by the 48 MHz DCM output.
// Holds the core in reset until lock has been stable for RST_CYCLES clocks,
// and derives the pixel enable and the two-phase CPU enable from the single
// 48 MHz clock, with a turbo option for the CPU rate.
// Ports:
//   clock     in  48 MHz clock
//   reset     in  async active-high, forces all registers to reset values
//   locked    in  DCM lock flag, asynchronous
//   turbo     in  CPU speed select, asynchronous
//   sys_reset out core reset, active high, synchronous deassert
//   ce_pix    out one-clock pulse every PIX_DIV clocks
//   ce_cpu_p  out one-clock pulse, CPU rising phase
//   ce_cpu_n  out one-clock pulse, CPU falling phase
module reset_ce
  import reset_ce_pkg::*;
#(
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int PIX_DIV    = DEF_PIX_DIV,
  parameter int CPU_NORMAL = DEF_CPU_NORMAL,
  parameter int CPU_TURBO  = DEF_CPU_TURBO
) (
  input  logic clock,
  input  logic reset,
  input  logic locked,
  input  logic turbo,
  output logic sys_reset,
  output logic ce_pix,
  output logic ce_cpu_p,
  output logic ce_cpu_n
);

  localparam int RW = $clog2(RST_CYCLES);
  localparam int PW = $clog2(PIX_DIV);
  localparam int CW = $clog2(maxOf(CPU_NORMAL, CPU_TURBO));

  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] PIX_LAST    = PW'(PIX_DIV - 1);
  localparam logic [CW-1:0] NORM_LAST   = CW'(CPU_NORMAL - 1);
  localparam logic [CW-1:0] NORM_HALF   = CW'(CPU_NORMAL / 2 - 1);
  localparam logic [CW-1:0] TURBO_LAST  = CW'(CPU_TURBO - 1);
  localparam logic [CW-1:0] TURBO_HALF  = CW'(CPU_TURBO / 2 - 1);

  logic locked_s;
  logic turbo_s;

  state_t        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          sys_reset_q, sys_reset_d;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic          div_sel_q, div_sel_d;
  logic          ce_pix_q, ce_pix_d;
  logic          ce_cpu_p_q, ce_cpu_p_d;
  logic          ce_cpu_n_q, ce_cpu_n_d;

  logic [CW-1:0] cur_last;
  logic [CW-1:0] next_last;
  logic [CW-1:0] next_half;

  reset_ce_sync2 u_sync_locked (
    .clock (clock),
    .reset (reset),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  reset_ce_sync2 u_sync_turbo (
    .clock (clock),
    .reset (reset),
    .d_i   (turbo),
    .q_o   (turbo_s)
  );

  // Reset sequencer: any loss of lock drops back to HOLD so that every lock
  // glitch restarts the full hold count from zero.
  always_comb begin
    state_d = state_q;
    rcnt_d  = '0;
    case (state_q)
      HOLD: begin
        if (locked_s) state_d = COUNT;
      end
      COUNT: begin
        if (!locked_s) begin
          state_d = HOLD;
        end else if (rcnt_q == RST_LAST) begin
          state_d = RUN;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) state_d = HOLD;
      end
      default: state_d = HOLD;
    endcase
    // Registered from the next state so the output changes on the same edge as the state.
    sys_reset_d = (state_d != RUN);
  end

  // Dividers run whenever lock is present, independent of sys_reset. The CPU
  // divisor is only reloaded at the wrap, so a speed change never produces a
  // truncated or stretched period. Enables are registered from the next
  // counter values so each pulse lines up with its counter state.
  always_comb begin
    cur_last  = div_sel_q ? TURBO_LAST : NORM_LAST;
    pcnt_d    = '0;
    ccnt_d    = '0;
    div_sel_d = div_sel_q;
    if (locked_s) begin
      pcnt_d = (pcnt_q == PIX_LAST) ? '0 : pcnt_q + 1'b1;
      if (ccnt_q == cur_last) begin
        ccnt_d    = '0;
        div_sel_d = turbo_s;
      end else begin
        ccnt_d = ccnt_q + 1'b1;
      end
    end
    next_last  = div_sel_d ? TURBO_LAST : NORM_LAST;
    next_half  = div_sel_d ? TURBO_HALF : NORM_HALF;
    ce_pix_d   = locked_s && (pcnt_d == PIX_LAST);
    ce_cpu_p_d = locked_s && (ccnt_d == next_half);
    ce_cpu_n_d = locked_s && (ccnt_d == next_last);
  end

  // All state and outputs share one register bank with async clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= HOLD;
      rcnt_q      <= '0;
      sys_reset_q <= 1'b1;
      pcnt_q      <= '0;
      ccnt_q      <= '0;
      div_sel_q   <= 1'b0;
      ce_pix_q    <= 1'b0;
      ce_cpu_p_q  <= 1'b0;
      ce_cpu_n_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      sys_reset_q <= sys_reset_d;
      pcnt_q      <= pcnt_d;
      ccnt_q      <= ccnt_d;
      div_sel_q   <= div_sel_d;
      ce_pix_q    <= ce_pix_d;
      ce_cpu_p_q  <= ce_cpu_p_d;
      ce_cpu_n_q  <= ce_cpu_n_d;
    end
  end

  assign sys_reset = sys_reset_q;
  assign ce_pix    = ce_pix_q;
  assign ce_cpu_p  = ce_cpu_p_q;
  assign ce_cpu_n  = ce_cpu_n_q;

endmodule

// File: tb/tb_reset_ce.sv
// Directed bench for reset_ce with a 16-clock reset hold.
module tb_reset_ce;
  import reset_ce_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic locked;
  logic turbo;
  logic sys_reset;
  logic ce_pix;
  logic ce_cpu_p;
  logic ce_cpu_n;

  int cycle = 0;
  int assertionCount = 0;
  int failureCount = 0;

  reset_ce #(
    .RST_CYCLES (16),
    .PIX_DIV    (DEF_PIX_DIV),
    .CPU_NORMAL (DEF_CPU_NORMAL),
    .CPU_TURBO  (DEF_CPU_TURBO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .locked    (locked),
    .turbo     (turbo),
    .sys_reset (sys_reset),
    .ce_pix    (ce_pix),
    .ce_cpu_p  (ce_cpu_p),
    .ce_cpu_n  (ce_cpu_n)
  );

  // 10 ns clock; posedges at 5, 15, 25 ...
  always #5 clock = ~clock;

  // Free-running cycle index used to timestamp enable pulses.
  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertionCount++;
    assert (observed === expected)
    else begin
      failureCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Step to just after the next n active edges.
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Wait (bounded) for an enable pulse; sel 0=pix 1=cpu_p 2=cpu_n. -1 on timeout.
  task automatic waitCe(input int sel, output int at);
    logic hit;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      hit = (sel == 0) ? ce_pix : (sel == 1) ? ce_cpu_p : ce_cpu_n;
      if (hit === 1'b1) begin
        at = cycle;
        break;
      end
    end
  endtask

  task automatic checkAllCeLow(input string tag);
    checkOutput({tag, "_pix"}, ce_pix, 1'b0);
    checkOutput({tag, "_cpu_p"}, ce_cpu_p, 1'b0);
    checkOutput({tag, "_cpu_n"}, ce_cpu_n, 1'b0);
  endtask

  initial begin
    int a, b, c, p1, p2, t0, t1, t2, t3, t4, t5, tp;
    int pulses, released;

    // Reset state, lock present from time zero.
    reset  = 1'b1;
    locked = 1'b1;
    turbo  = 1'b0;
    #2;
    checkOutput("rst_sys_reset", sys_reset, 1'b1);
    checkAllCeLow("rst");

    // Test 1: release reset; sys_reset must fall exactly at edge 19.
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(18);
    checkOutput("t1_edge18_still_reset", sys_reset, 1'b1);
    applyStimulus(1);
    checkOutput("t1_edge19_released", sys_reset, 1'b0);

    // Test 3: normal speed enable spacing.
    waitCe(2, a);
    waitCe(1, b);
    waitCe(2, c);
    checkOutput("t3_cpu_n_period", c - a, 12);
    checkOutput("t3_p_to_n_gap", c - b, 6);
    checkOutput("t3_not_both", ce_cpu_p, 1'b0);
    waitCe(0, p1);
    waitCe(0, p2);
    checkOutput("t3_pix_period", p2 - p1, 4);

    // Test 4: switch to turbo at ccnt=5, then back at ccnt=1 of a turbo period.
    waitCe(2, t0);
    applyStimulus(6);
    turbo = 1'b1;
    waitCe(2, t1);
    checkOutput("t4_finish_normal", t1 - t0, 12);
    waitCe(1, tp);
    waitCe(2, t2);
    checkOutput("t4_turbo_period1", t2 - t1, 8);
    checkOutput("t4_turbo_p_to_n", t2 - tp, 4);
    waitCe(2, t3);
    checkOutput("t4_turbo_period2", t3 - t2, 8);
    applyStimulus(2);
    turbo = 1'b0;
    waitCe(2, t4);
    checkOutput("t4_finish_turbo", t4 - t3, 8);
    waitCe(2, t5);
    checkOutput("t4_back_normal", t5 - t4, 12);
    checkOutput("t4_still_running", sys_reset, 1'b0);

    // Test 2: lock lost for 3 clocks in RUN, then regained.
    locked = 1'b0;
    applyStimulus(3);
    checkOutput("t2_unlock_reset", sys_reset, 1'b1);
    checkAllCeLow("t2_unlock");
    locked = 1'b1;
    applyStimulus(18);
    checkOutput("t2_relock_edge18", sys_reset, 1'b1);
    applyStimulus(1);
    checkOutput("t2_relock_edge19", sys_reset, 1'b0);

    // Test 5a: reset pulsed during RUN acts immediately.
    applyStimulus(5);
    reset = 1'b1;
    #1;
    checkOutput("t5_run_async_reset", sys_reset, 1'b1);
    checkAllCeLow("t5_run");
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(8);
    // Test 5b: reset pulsed during COUNT restarts the whole hold.
    reset = 1'b1;
    #1;
    checkOutput("t5_count_async_reset", sys_reset, 1'b1);
    checkAllCeLow("t5_count");
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(18);
    checkOutput("t5_edge18", sys_reset, 1'b1);
    applyStimulus(1);
    checkOutput("t5_edge19", sys_reset, 1'b0);

    // Test 6: no lock at all for 1000 clocks.
    reset  = 1'b1;
    locked = 1'b0;
    @(negedge clock);
    reset    = 1'b0;
    pulses   = 0;
    released = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (ce_pix !== 1'b0 || ce_cpu_p !== 1'b0 || ce_cpu_n !== 1'b0) pulses++;
      if (sys_reset !== 1'b1) released++;
    end
    checkOutput("t6_no_ce_pulses", pulses, 0);
    checkOutput("t6_never_released", released, 0);
    checkOutput("t6_sys_reset_high", sys_reset, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertionCount, failureCount);
    $finish;
  end

endmodule
